// File: rtl/fp_handshake_responder_if.sv
// rtl/fp_handshake_responder_if.sv - operand/result stb/ack and core-launch signal bundle
interface fp_handshake_responder_if;
    logic [1:0]  process;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic        core_start;
    logic [63:0] core_a;
    logic [63:0] core_b;
    logic        core_double;
    logic        core_sqrt;
    logic        core_done;
    logic [63:0] core_z;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
    logic        timeout;

    modport slave (
        input  process, input_a, input_a_stb, input_b, input_b_stb,
        input  core_done, core_z, output_z_ack,
        output input_a_ack, input_b_ack, core_start, core_a, core_b,
        output core_double, core_sqrt, output_z, output_z_stb, timeout
    );

    modport master (
        output process, input_a, input_a_stb, input_b, input_b_stb,
        output core_done, core_z, output_z_ack,
        input  input_a_ack, input_b_ack, core_start, core_a, core_b,
        input  core_double, core_sqrt, output_z, output_z_stb, timeout
    );
endinterface

// File: rtl/fp_handshake_responder.sv
// rtl/fp_handshake_responder.sv - FP unit responder: operand capture, core launch, watchdog, result hold
module fp_handshake_responder #(
    parameter int TIMEOUT = 1024
) (
    input  logic                    fpga_clk,
    input  logic                    rst,
    fp_handshake_responder_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [63:0] NAN_S = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] NAN_D = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {GET_A, GET_B, START, WAIT_CORE, PUT_Z} state_t;

    state_t         state_q, state_d;
    logic [63:0]    a_q, a_d, b_q, b_d, z_q, z_d;
    logic           dbl_q, dbl_d, sqrt_q, sqrt_d, to_q, to_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           a_ack_q, b_ack_q, start_q, z_stb_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        dbl_d   = dbl_q;
        sqrt_d  = sqrt_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        case (state_q)
            GET_A: begin
                if (bus.input_a_stb && a_ack_q) begin
                    a_d    = bus.process[1] ? bus.input_a : {32'b0, bus.input_a[31:0]};
                    dbl_d  = bus.process[1];
                    sqrt_d = bus.process[0];
                    if (bus.process[0]) begin
                        b_d     = 64'b0;
                        state_d = START;
                    end else begin
                        state_d = GET_B;
                    end
                end
            end
            GET_B: begin
                if (bus.input_b_stb && b_ack_q) begin
                    b_d     = dbl_q ? bus.input_b : {32'b0, bus.input_b[31:0]};
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                // The result must be visible TIMEOUT cycles after the launch pulse.
                cnt_d = cnt_q + CW'(1);
                if (bus.core_done) begin
                    z_d     = dbl_q ? bus.core_z : {32'b0, bus.core_z[31:0]};
                    to_d    = 1'b0;
                    state_d = PUT_Z;
                end else if (cnt_d == CW'(TIMEOUT - 1)) begin
                    z_d     = dbl_q ? NAN_D : NAN_S;
                    to_d    = 1'b1;
                    state_d = PUT_Z;
                end
            end
            PUT_Z: begin
                if (bus.output_z_ack) state_d = GET_A;
            end
            default: state_d = GET_A;
        endcase
    end

    // Handshake outputs are registered from the next state so they are glitch-free and zero in reset.
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            dbl_q   <= 1'b0;
            sqrt_q  <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            start_q <= 1'b0;
            z_stb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            dbl_q   <= dbl_d;
            sqrt_q  <= sqrt_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            a_ack_q <= (state_d == GET_A);
            b_ack_q <= (state_d == GET_B);
            start_q <= (state_d == START);
            z_stb_q <= (state_d == PUT_Z);
        end
    end

    assign bus.input_a_ack  = a_ack_q;
    assign bus.input_b_ack  = b_ack_q;
    assign bus.core_start   = start_q;
    assign bus.core_a       = a_q;
    assign bus.core_b       = b_q;
    assign bus.core_double  = dbl_q;
    assign bus.core_sqrt    = sqrt_q;
    assign bus.output_z     = z_q;
    assign bus.output_z_stb = z_stb_q;
    assign bus.timeout      = to_q;
endmodule

// File: tb/tb_fp_handshake_responder.sv
// tb/tb_fp_handshake_responder.sv - scoreboard bench for fp_handshake_responder
module tb_fp_handshake_responder;
    localparam int TIMEOUT = 16;
    localparam logic [63:0] NAN_S = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] NAN_D = 64'h7FF8_0000_0000_0000;

    typedef struct {
        logic [63:0] z;
        logic        to;
        int          lat;
    } exp_t;

    logic fpga_clk = 1'b0;
    logic rst = 1'b1;
    always #5 fpga_clk = ~fpga_clk;

    fp_handshake_responder_if bus();

    fp_handshake_responder #(.TIMEOUT(TIMEOUT)) dut (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .bus      (bus)
    );

    int tests = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int a_acc = 0, b_acc = 0, starts = 0, stb_rises = 0;
    exp_t sbq[$];
    logic [63:0] exp_a, exp_b, core_res;
    logic exp_dbl, exp_sqrt, txn_sqrt;
    int core_delay = 1;
    bit core_busy = 0;
    logic mon_prev = 1'b0;
    logic [63:0] held_z;
    logic held_to;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] msk(input logic [63:0] v, input logic dbl);
        return dbl ? v : {32'b0, v[31:0]};
    endfunction

    always @(posedge fpga_clk) cyc <= cyc + 1;

    always @(negedge fpga_clk) begin
        if (bus.input_a_stb && bus.input_a_ack) a_acc++;
        if (bus.input_b_stb && bus.input_b_ack) b_acc++;
        if (bus.core_start) starts++;
        check("acks_exclusive", 64'(bus.input_a_ack && bus.input_b_ack), 64'd0);
        if (txn_sqrt) check("b_ack_in_sqrt", 64'(bus.input_b_ack), 64'd0);
    end

    // Core model: answers core_delay cycles after launch, or never when core_delay < 1.
    initial begin
        bus.core_done = 1'b0;
        bus.core_z    = '0;
        forever begin
            tick();
            bus.core_z = rnd64();
            if (bus.core_start && !rst) begin
                start_cyc = cyc;
                check("core_a", bus.core_a, exp_a);
                check("core_b", bus.core_b, exp_b);
                check("core_double", 64'(bus.core_double), 64'(exp_dbl));
                check("core_sqrt", 64'(bus.core_sqrt), 64'(exp_sqrt));
                if (core_delay >= 1) begin
                    core_busy = 1;
                    repeat (core_delay) begin
                        tick();
                        bus.core_z = rnd64();
                    end
                    bus.core_done = 1'b1;
                    bus.core_z    = core_res;
                    tick();
                    bus.core_done = 1'b0;
                    bus.core_z    = rnd64();
                    core_busy = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each new result and checks it is held while stalled.
    initial begin
        exp_t e;
        forever begin
            tick();
            if (bus.output_z_stb && !mon_prev) begin
                stb_rises++;
                if (sbq.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_z_stb: got z=%h expected no result", bus.output_z);
                end else begin
                    e = sbq.pop_front();
                    check("output_z", bus.output_z, e.z);
                    check("timeout", 64'(bus.timeout), 64'(e.to));
                    check("z_latency", 64'(cyc - start_cyc), 64'(e.lat));
                end
                held_z  = bus.output_z;
                held_to = bus.timeout;
            end else if (bus.output_z_stb) begin
                check("z_hold", bus.output_z, held_z);
                check("timeout_hold", 64'(bus.timeout), 64'(held_to));
            end
            mon_prev = bus.output_z_stb;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (core_busy && n < 100) begin
            tick();
            n++;
        end
        check("core_idle", 64'(core_busy), 64'd0);
    endtask

    task automatic run_txn(input logic [1:0] proc, input logic [63:0] a, input logic [63:0] b,
                           input int delay, input int hold, input int ack_wait,
                           input logic [63:0] res);
        exp_t e;
        int n, a0, b0, s0, acc_cyc;
        wait_idle();
        exp_a    = msk(a, proc[1]);
        exp_b    = proc[0] ? 64'd0 : msk(b, proc[1]);
        exp_dbl  = proc[1];
        exp_sqrt = proc[0];
        txn_sqrt = proc[0];
        core_delay = delay;
        core_res   = res;
        if (delay >= 1 && delay < TIMEOUT) begin
            e.z = msk(res, proc[1]); e.to = 1'b0; e.lat = delay + 1;
        end else begin
            e.z = proc[1] ? NAN_D : NAN_S; e.to = 1'b1; e.lat = TIMEOUT;
        end
        sbq.push_back(e);
        a0 = a_acc; b0 = b_acc; s0 = starts;
        bus.process = proc; bus.input_a = a; bus.input_a_stb = 1'b1;
        n = 0;
        while (!bus.input_a_ack && n < 50) begin tick(); n++; end
        tick();
        acc_cyc = cyc;
        if (hold == 0) begin
            bus.input_a_stb = 1'b0; bus.process = 2'($urandom); bus.input_a = rnd64();
        end
        if (!proc[0]) begin
            bus.input_b = b; bus.input_b_stb = 1'b1;
            n = 0;
            while (!bus.input_b_ack && n < 50) begin tick(); n++; end
            tick();
            if (hold == 0) begin bus.input_b_stb = 1'b0; bus.input_b = rnd64(); end
        end
        repeat (hold) tick();
        bus.input_a_stb = 1'b0; bus.input_b_stb = 1'b0;
        bus.process = 2'($urandom); bus.input_a = rnd64(); bus.input_b = rnd64();
        n = 0;
        while (!bus.output_z_stb && n < 200) begin tick(); n++; end
        check("z_stb_seen", 64'(bus.output_z_stb), 64'd1);
        repeat (ack_wait) tick();
        bus.output_z_ack = 1'b1;
        tick();
        bus.output_z_ack = 1'b0;
        check("z_stb_drop", 64'(bus.output_z_stb), 64'd0);
        check("a_ack_return", 64'(bus.input_a_ack), 64'd1);
        check("a_accepts", 64'(a_acc - a0), 64'd1);
        check("b_accepts", 64'(b_acc - b0), proc[0] ? 64'd0 : 64'd1);
        check("start_pulses", 64'(starts - s0), 64'd1);
        if (proc[0]) check("sqrt_start_latency", 64'(start_cyc - acc_cyc), 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, 64'(|{bus.input_a_ack, bus.input_b_ack, bus.core_start, bus.core_a, bus.core_b,
                          bus.core_double, bus.core_sqrt, bus.output_z, bus.output_z_stb, bus.timeout}),
              64'd0);
    endtask

    initial begin
        int n, r0;
        bus.process = 2'd0; bus.input_a = '0; bus.input_a_stb = 1'b0;
        bus.input_b = '0; bus.input_b_stb = 1'b0; bus.output_z_ack = 1'b0;
        txn_sqrt = 1'b0; exp_a = '0; exp_b = '0; exp_dbl = 1'b0; exp_sqrt = 1'b0; core_res = '0;
        rst = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset_outputs");
        rst = 1'b0;
        tick();
        check("a_ack_after_reset", 64'(bus.input_a_ack), 64'd1);

        run_txn(2'd0, 64'h3F80_0000, 64'h4000_0000, 5, 0, 0, 64'hDEAD_BEEF_3F00_0000);
        run_txn(2'd1, 64'h4080_0000, rnd64(), 3, 0, 0, 64'h0000_0000_4000_0000);
        run_txn(2'd2, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 12, 10, 0, rnd64());
        run_txn(2'd3, rnd64(), rnd64(), 4, 0, 20, rnd64());
        run_txn(2'd2, rnd64(), rnd64(), -1, 0, 2, rnd64());
        run_txn(2'd0, rnd64(), rnd64(), -1, 0, 1, rnd64());
        run_txn(2'd1, rnd64(), rnd64(), TIMEOUT - 1, 0, 0, rnd64());
        run_txn(2'd3, rnd64(), rnd64(), 1, 0, 0, rnd64());
        for (int i = 0; i < 14; i++)
            run_txn(2'($urandom), rnd64(), rnd64(), int'($urandom_range(1, 20)), 0,
                    int'($urandom_range(0, 5)), rnd64());

        // Abort mid-operation: the late core_done must not produce a result.
        wait_idle();
        exp_a = msk(64'h1234_5678_9ABC_DEF0, 1'b1); exp_b = 64'd0;
        exp_dbl = 1'b1; exp_sqrt = 1'b1; txn_sqrt = 1'b1;
        core_delay = 10; core_res = rnd64();
        bus.process = 2'd3; bus.input_a = 64'h1234_5678_9ABC_DEF0; bus.input_a_stb = 1'b1;
        n = 0;
        while (!bus.input_a_ack && n < 50) begin tick(); n++; end
        tick();
        bus.input_a_stb = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check_outputs_zero("mid_reset_outputs");
        tick();
        rst = 1'b0;
        r0 = stb_rises;
        repeat (25) tick();
        check("no_z_after_reset", 64'(stb_rises - r0), 64'd0);
        check("a_ack_after_abort", 64'(bus.input_a_ack), 64'd1);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no completion expected finish within bound");
        $fatal(1, "bench timed out");
    end
endmodule
